// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// address slicing widths and the controller state encoding.
package cache_ctrl_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int DEF_ENTRY_WIDTH  = 10;
  localparam int DEF_OFFSET_WIDTH = 2;
  localparam int TAG_WIDTH        = ADDR_WIDTH - DEF_ENTRY_WIDTH - DEF_OFFSET_WIDTH;

  localparam int STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_LOOKUP = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_MEM_RD = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_FILL   = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_MEM_WR = 3'd4;

endpackage

// File: rtl/cache_ctrl_tag_array.sv
// Tag and valid storage for the direct-mapped cache: combinational read by
// index, single write port, valid bits cleared by synchronous reset.
module cache_tag_array
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_OF_ENTRY = 1024,
  parameter int ENTRY_WIDTH  = DEF_ENTRY_WIDTH,
  parameter int TAG_BITS     = TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENTRY_WIDTH-1:0] i_rdIdx,
  output logic [TAG_BITS-1:0]    o_rdTag,
  output logic                   o_rdValid,
  input  logic                   i_wrEn,
  input  logic [ENTRY_WIDTH-1:0] i_wrIdx,
  input  logic [TAG_BITS-1:0]    i_wrTag,
  input  logic                   i_setValid
);

  logic [TAG_BITS-1:0]     r_tags [NUM_OF_ENTRY];
  logic [NUM_OF_ENTRY-1:0] r_valid;

  assign o_rdTag   = r_tags[i_rdIdx];
  assign o_rdValid = r_valid[i_rdIdx];

  // Tag contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_tags[i_wrIdx] <= i_wrTag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wrEn) begin
      r_valid[i_wrIdx] <= i_setValid;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-entry, write-through, no-write-allocate cache
// controller; the data array lives outside and is driven via index/we/din/dout.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_OF_ENTRY = 1024,
  parameter int ENTRY_WIDTH  = DEF_ENTRY_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic [ENTRY_WIDTH-1:0] index,
  output logic                   we,
  output logic [DATA_WIDTH-1:0]  din,
  input  logic [DATA_WIDTH-1:0]  dout,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  localparam int TAG_BITS = ADDR_WIDTH - ENTRY_WIDTH - OFFSET_WIDTH;

  logic [STATE_WIDTH-1:0] r_state;
  logic                   r_we;
  logic [TAG_BITS-1:0]    r_tag;
  logic [ENTRY_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_fillData;

  logic [STATE_WIDTH-1:0] w_nextState;
  logic [TAG_BITS-1:0]    w_storedTag;
  logic                   w_storedValid;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_inLookup;
  logic                   w_inFill;
  logic                   w_readHit;
  logic                   w_writeHit;
  logic                   w_unusedOffset;

  // Byte offset only selects a byte within the word, which the cache ignores.
  assign w_unusedOffset = ^cpu_addr[OFFSET_WIDTH-1:0];

  cache_tag_array #(
    .NUM_OF_ENTRY(NUM_OF_ENTRY),
    .ENTRY_WIDTH (ENTRY_WIDTH),
    .TAG_BITS    (TAG_BITS)
  ) u_tagArray (
    .clk       (clk),
    .rst       (rst),
    .i_rdIdx   (r_idx),
    .o_rdTag   (w_storedTag),
    .o_rdValid (w_storedValid),
    .i_wrEn    (w_inFill),
    .i_wrIdx   (r_idx),
    .i_wrTag   (r_tag),
    .i_setValid(1'b1)
  );

  assign w_accept   = (r_state == ST_IDLE) && cpu_req;
  assign w_inLookup = (r_state == ST_LOOKUP);
  assign w_inFill   = (r_state == ST_FILL);
  assign w_hit      = w_storedValid && (w_storedTag == r_tag);
  assign w_readHit  = w_inLookup && !r_we && w_hit;
  assign w_writeHit = w_inLookup && r_we && w_hit;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (cpu_req) w_nextState = ST_LOOKUP;
      ST_LOOKUP: begin
        if (r_we)       w_nextState = ST_MEM_WR;
        else if (w_hit) w_nextState = ST_IDLE;
        else            w_nextState = ST_MEM_RD;
      end
      ST_MEM_RD: if (mem_ack) w_nextState = ST_FILL;
      ST_FILL:   w_nextState = ST_IDLE;
      ST_MEM_WR: if (mem_ack) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_fillData <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_we    <= cpu_we;
        r_tag   <= cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
        r_idx   <= cpu_addr[OFFSET_WIDTH +: ENTRY_WIDTH];
        r_wdata <= cpu_wdata;
      end
      if ((r_state == ST_MEM_RD) && mem_ack) begin
        r_fillData <= mem_rdata;
      end
    end
  end

  // Memory-side outputs are derived from latched state only, so they stay
  // stable for the whole time mem_req is high.
  assign cpu_ready = (r_state == ST_IDLE);
  assign cpu_done  = w_readHit || w_inFill || ((r_state == ST_MEM_WR) && mem_ack);
  assign cpu_rdata = w_readHit ? dout : (w_inFill ? r_fillData : '0);
  assign index     = (w_inLookup || w_inFill) ? r_idx : '0;
  assign we        = w_writeHit || w_inFill;
  assign din       = w_writeHit ? r_wdata : (w_inFill ? r_fillData : '0);
  assign mem_req   = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign mem_we    = (r_state == ST_MEM_WR);
  assign mem_addr  = mem_req ? {r_tag, r_idx, {OFFSET_WIDTH{1'b0}}} : '0;
  assign mem_wdata = mem_we ? r_wdata : '0;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: models the external data array and drives
// the memory handshake by hand, checking against hand-computed values.
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [9:0]  index;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int acceptCnt = 0;
  int doneCnt = 0;
  int accept0;
  int done0;

  logic [31:0] tbDataMem [1024];

  cache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_done (cpu_done),
    .cpu_rdata(cpu_rdata),
    .index    (index),
    .we       (we),
    .din      (din),
    .dout     (dout),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External data array: written on we, read combinationally by index.
  always @(posedge clk) begin
    if (we) tbDataMem[index] <= din;
  end
  assign dout = tbDataMem[index];

  always @(posedge clk) begin
    if (!rst && cpu_req && cpu_ready) acceptCnt++;
    if (cpu_done) doneCnt++;
  end

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ack,
                               input logic [31:0] rdata);
    @(negedge clk);
    cpu_req   = req;
    cpu_we    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ack   = ack;
    mem_rdata = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
    checkOutput("rst_done", 32'(cpu_done), 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_index", 32'(index), 32'd0);
    checkOutput("rst_we_din", {31'd0, we} | din, 32'd0);
    checkOutput("rst_mem", {30'd0, mem_req, mem_we} | mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;

    $display("[TB] read miss 0x8 with 3-cycle memory");
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd1_accept_ready", 32'(cpu_ready), 32'd1);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd1_lookup_index", 32'(index), 32'd2);
    checkOutput("rd1_lookup_done", 32'(cpu_done), 32'd0);
    checkOutput("rd1_lookup_ready", 32'(cpu_ready), 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd1_memreq_c1", 32'(mem_req), 32'd1);
    checkOutput("rd1_memaddr_c1", mem_addr, 32'h8);
    checkOutput("rd1_memwe_c1", 32'(mem_we), 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd1_memaddr_c2", mem_addr, 32'h8);
    applyStimulus(0, 0, 32'h8, 32'h0, 1, 32'h0000_0FF0);
    checkOutput("rd1_memreq_c3", 32'(mem_req), 32'd1);
    checkOutput("rd1_done_c3", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd1_fill_we", 32'(we), 32'd1);
    checkOutput("rd1_fill_index", 32'(index), 32'd2);
    checkOutput("rd1_fill_din", din, 32'h0000_0FF0);
    checkOutput("rd1_fill_done", 32'(cpu_done), 32'd1);
    checkOutput("rd1_fill_rdata", cpu_rdata, 32'h0000_0FF0);

    $display("[TB] read hit 0x8 right after fill");
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd2_ready", 32'(cpu_ready), 32'd1);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd2_done", 32'(cpu_done), 32'd1);
    checkOutput("rd2_rdata", cpu_rdata, 32'h0000_0FF0);
    checkOutput("rd2_memreq", 32'(mem_req), 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rd2_idle_done", 32'(cpu_done), 32'd0);

    $display("[TB] write hit 0x8 data 0xABCD");
    applyStimulus(1, 1, 32'h8, 32'h0000_ABCD, 0, 32'h0);
    applyStimulus(0, 1, 32'h8, 32'h0000_ABCD, 0, 32'h0);
    checkOutput("wr1_we", 32'(we), 32'd1);
    checkOutput("wr1_index", 32'(index), 32'd2);
    checkOutput("wr1_din", din, 32'h0000_ABCD);
    checkOutput("wr1_lookup_done", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("wr1_memreq", {30'd0, mem_req, mem_we}, 32'd3);
    checkOutput("wr1_memaddr", mem_addr, 32'h8);
    checkOutput("wr1_memwdata", mem_wdata, 32'h0000_ABCD);
    checkOutput("wr1_wait_done", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0);
    checkOutput("wr1_ack_done", 32'(cpu_done), 32'd1);
    checkOutput("wr1_ack_rdata", cpu_rdata, 32'd0);
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("wr1_rdback_done", 32'(cpu_done), 32'd1);
    checkOutput("wr1_rdback_rdata", cpu_rdata, 32'h0000_ABCD);
    checkOutput("wr1_rdback_memreq", 32'(mem_req), 32'd0);

    $display("[TB] write miss 0x1008, zero-wait ack");
    applyStimulus(1, 1, 32'h1008, 32'h0000_1234, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("wr2_we", 32'(we), 32'd0);
    checkOutput("wr2_index", 32'(index), 32'd2);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0);
    checkOutput("wr2_memaddr", mem_addr, 32'h1008);
    checkOutput("wr2_memwdata", mem_wdata, 32'h0000_1234);
    checkOutput("wr2_done", 32'(cpu_done), 32'd1);
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("wr2_ready", 32'(cpu_ready), 32'd1);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("wr2_rdback_done", 32'(cpu_done), 32'd1);
    checkOutput("wr2_rdback_rdata", cpu_rdata, 32'h0000_ABCD);

    $display("[TB] reset during memory read");
    applyStimulus(1, 0, 32'h2008, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("rst3_lookup_done", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("rst3_memaddr", mem_addr, 32'h2008);
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0000_DEAD);
    rst = 1'b0;
    checkOutput("rst3_nodone", 32'(cpu_done), 32'd0);
    checkOutput("rst3_nowe", 32'(we), 32'd0);
    checkOutput("rst3_ready", 32'(cpu_ready), 32'd1);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h0000_DEAD);
    checkOutput("rst3_lateack_done", {30'd0, cpu_done, mem_req}, 32'd0);
    checkOutput("rst3_array_intact", tbDataMem[2], 32'h0000_ABCD);
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rst3_miss_done", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h8, 32'h0, 1, 32'h0000_5555);
    checkOutput("rst3_miss_memaddr", mem_addr, 32'h8);
    applyStimulus(0, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("rst3_fill_din", din, 32'h0000_5555);
    checkOutput("rst3_fill_rdata", cpu_rdata, 32'h0000_5555);

    $display("[TB] cpu_req held high while busy");
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    accept0 = acceptCnt;
    done0   = doneCnt;
    checkOutput("hold_ready0", 32'(cpu_ready), 32'd1);
    applyStimulus(1, 0, 32'h8, 32'h0, 0, 32'h0);
    checkOutput("hold_lookup_ready", 32'(cpu_ready), 32'd0);
    checkOutput("hold_hit_rdata", cpu_rdata, 32'h0000_5555);
    applyStimulus(1, 1, 32'h10, 32'h77, 0, 32'h0);
    checkOutput("hold_idle_done", {30'd0, cpu_ready, cpu_done}, 32'd2);
    applyStimulus(1, 1, 32'h10, 32'h77, 0, 32'h0);
    checkOutput("hold_wlookup", {30'd0, we, cpu_done}, 32'd0);
    applyStimulus(1, 1, 32'h10, 32'h77, 1, 32'h0);
    checkOutput("hold_memwr_done", 32'(cpu_done), 32'd1);
    checkOutput("hold_memwr_addr", mem_addr, 32'h10);
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 32'h0);
    checkOutput("hold_idle2", {30'd0, cpu_ready, cpu_done}, 32'd2);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("hold_rlookup", {22'd0, index}, 32'd4);
    checkOutput("hold_rlookup_done", 32'(cpu_done), 32'd0);
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'h99);
    checkOutput("hold_rd_addr", mem_addr, 32'h10);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("hold_fill_rdata", cpu_rdata, 32'h99);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("hold_accepts", 32'(acceptCnt - accept0), 32'd3);
    checkOutput("hold_dones", 32'(doneCnt - done0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter NUM_OF_ENTRY, default 1024, number of direct-mapped cache entries.
REQ-002 Parameter ENTRY_WIDTH, default 10, index width.
REQ-003 Parameter DATA_WIDTH, default 32, word width.
REQ-004 Parameter OFFSET_WIDTH, default 2, byte-offset width; TAG_WIDTH = 32 - ENTRY_WIDTH - OFFSET_WIDTH (default 20).
REQ-005 Ports SHALL be as follows, one clock, reset synchronous and active-high:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  controller idle; request accepted when cpu_req && cpu_ready.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data, valid when cpu_done on a read.
- index  out  ENTRY_WIDTH  cache_block entry index.
- we  out  1  cache_block write enable, one-cycle pulse.
- din  out  DATA_WIDTH  cache_block write data.
- dout  in  DATA_WIDTH  cache_block read data, combinational from index.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-006 Policy SHALL be direct-mapped, one word per entry, write-through, no-write-allocate.
REQ-007 Address split SHALL be tag = addr[31:12], idx = addr[11:2]; offset ignored; mem_addr = {tag, idx, 2'b00}.
REQ-008 FSM states SHALL be IDLE, LOOKUP, MEM_RD, FILL, MEM_WR.
REQ-009 IDLE: cpu_ready=1; on accept, latch cpu_we/cpu_addr/cpu_wdata -> LOOKUP; otherwise stay.
REQ-010 In every state except IDLE, cpu_ready SHALL be 0 and cpu_req SHALL be ignored.
REQ-011 index SHALL equal the latched idx in LOOKUP and FILL, and 0 otherwise.
REQ-012 hit = valid[idx] && stored_tag[idx] == tag, evaluated in LOOKUP.
REQ-013 LOOKUP read hit: cpu_done=1, cpu_rdata=dout -> IDLE; latency 2 cycles from accept edge.
REQ-014 LOOKUP read miss -> MEM_RD.
REQ-015 LOOKUP write hit: we=1, din=wdata (entry updated at that edge) -> MEM_WR.
REQ-016 LOOKUP write miss: no cache write, tag/valid unchanged -> MEM_WR.
REQ-017 MEM_RD: mem_req=1, mem_we=0, hold until mem_ack; on mem_ack, capture mem_rdata -> FILL.
REQ-018 FILL: we=1, din=captured data; stored_tag[idx]=tag and valid[idx]=1 at the edge; cpu_done=1, cpu_rdata=captured data -> IDLE.
REQ-019 MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata, hold until mem_ack; on mem_ack, cpu_done=1 (cpu_rdata=0) -> IDLE.
REQ-020 mem_ack in the first cycle of MEM_RD/MEM_WR SHALL complete that transfer (zero wait); mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-021 mem_req, mem_we, mem_addr and mem_wdata SHALL be stable while mem_req=1.
REQ-022 Back-to-back: a request accepted in the IDLE cycle following cpu_done SHALL be serviced normally; a read immediately after a fill to the same address SHALL hit.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, all valid bits cleared, latched request cleared.
REQ-024 Outputs after reset: cpu_ready=1, cpu_done=0, cpu_rdata=0, index=0, we=0, din=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-operation SHALL abandon the transfer with no cpu_done and no cache write; a later mem_ack SHALL be ignored.
REQ-026 stored_tag contents need no reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, TAG_WIDTH, and the address-slice widths.
REQ-028 Tag and valid storage SHALL be one sub-module, cache_tag_array, providing combinational read by idx, write port (idx, tag, set_valid), and synchronous valid clear on rst.

Verification
REQ-029 Reset, then read 0x0000_0008 with mem returning 0x0000_0FF0 after 3 cycles -> mem_req with mem_addr=0x8, FILL we=1 index=2 din=0x0FF0, cpu_done, cpu_rdata=0x0FF0.
REQ-030 Repeat read 0x0000_0008 -> no mem_req; cpu_done 2 cycles after accept; cpu_rdata=0x0FF0.
REQ-031 Write 0x0000_0008 data 0xABCD (hit) -> we=1 index=2 din=0xABCD in LOOKUP; memory write addr 0x8; next read returns 0xABCD with no mem_req.
REQ-032 Write 0x0000_1008 (idx 2, different tag) -> no we, memory write only; read 0x0000_0008 still hits with 0xABCD.
REQ-033 rst asserted during MEM_RD, then mem_ack -> no cpu_done, no we; read 0x0000_0008 misses (valid cleared).
REQ-034 Zero-wait mem_ack, and cpu_req held high during busy -> exactly one accept per cpu_ready cycle; no duplicate cpu_done.
